// File: rtl/div_seq.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// Handles signed operands, divide-by-zero and the signed overflow case.
module div_seq #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] quotient_o,
    output logic [DATA_W-1:0] remainder_o,
    output logic              div_by_zero_o,
    output logic              busy_o
);

    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] dvs_q, dvs_d;
    logic [DATA_W-1:0] qout_q, qout_d;
    logic [DATA_W-1:0] rout_q, rout_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              negq_q, negq_d;
    logic              negr_q, negr_d;
    logic              dbz_q, dbz_d;

    logic [DATA_W-1:0] a_mag, b_mag;
    logic [DATA_W:0]   t, d;
    logic              ge;
    logic [DATA_W-1:0] rem_nx, quo_nx;

    always_comb begin
        a_mag = (signed_i && dividend_i[DATA_W-1]) ? -dividend_i : dividend_i;
        b_mag = (signed_i && divisor_i[DATA_W-1]) ? -divisor_i : divisor_i;

        // Partial remainder stays below the divisor, so t - d fits in DATA_W bits.
        t      = {rem_q, quo_q[DATA_W-1]};
        d      = {1'b0, dvs_q};
        ge     = (t >= d);
        rem_nx = ge ? (t[DATA_W-1:0] - dvs_q) : t[DATA_W-1:0];
        quo_nx = {quo_q[DATA_W-2:0], ge};

        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        qout_d  = qout_q;
        rout_d  = rout_q;
        cnt_d   = cnt_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dbz_d   = dbz_q;

        if (clear_i) begin
            state_d = IDLE;
            dbz_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        negq_d = signed_i &
                                 (dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1]);
                        negr_d = signed_i & dividend_i[DATA_W-1];
                        rem_d  = '0;
                        quo_d  = a_mag;
                        dvs_d  = b_mag;
                        cnt_d  = CW'(DATA_W - 1);
                        if (divisor_i == '0) begin
                            state_d = DONE;
                            qout_d  = '1;
                            rout_d  = dividend_i;
                            dbz_d   = 1'b1;
                        end else begin
                            state_d = CALC;
                            dbz_d   = 1'b0;
                        end
                    end
                end
                CALC: begin
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        state_d = DONE;
                        qout_d  = negq_q ? -quo_nx : quo_nx;
                        rout_d  = negr_q ? -rem_nx : rem_nx;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            qout_q  <= '0;
            rout_q  <= '0;
            cnt_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            qout_q  <= qout_d;
            rout_q  <= rout_d;
            cnt_q   <= cnt_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready_o    = (state_q == IDLE);
    assign busy_o        = (state_q != IDLE);
    assign out_valid_o   = (state_q == DONE);
    assign quotient_o    = qout_q;
    assign remainder_o   = rout_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: arithmetic model plus per-cycle output checker.
// Literal expectations pin the model; latency, backpressure, abort, reset.
module tb_div_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clear_i = 1'b0;
    logic         in_valid_i = 1'b0;
    logic         in_ready_o;
    logic         signed_i = 1'b0;
    logic [W-1:0] dividend_i = '0;
    logic [W-1:0] divisor_i = '0;
    logic         out_valid_o;
    logic         out_ready_i = 1'b0;
    logic [W-1:0] quotient_o;
    logic [W-1:0] remainder_o;
    logic         div_by_zero_o;
    logic         busy_o;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q, exp_r;
    logic         exp_z;
    bit           exp_live = 1'b0;

    div_seq #(.DATA_W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (clear_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .signed_i     (signed_i),
        .dividend_i   (dividend_i),
        .divisor_i    (divisor_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .quotient_o   (quotient_o),
        .remainder_o  (remainder_o),
        .div_by_zero_o(div_by_zero_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Truncating division; remainder takes the dividend's sign.
    function automatic void model(input bit s, input logic [W-1:0] a,
                                  input logic [W-1:0] b,
                                  output logic [W-1:0] q,
                                  output logic [W-1:0] r,
                                  output logic z);
        longint sa, sb, lq, lr;
        if (b == '0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else if (!s) begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[W-1:0];
            r  = lr[W-1:0];
            z  = 1'b0;
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid_o) begin
            if (!exp_live) begin
                chk("spurious_valid", 32'(out_valid_o), 32'd0);
            end else begin
                chk("cmp_quotient", quotient_o, exp_q);
                chk("cmp_remainder", remainder_o, exp_r);
                chk("cmp_dbz", 32'(div_by_zero_o), 32'(exp_z));
                chk("cmp_in_ready", 32'(in_ready_o), 32'd0);
                chk("cmp_busy", 32'(busy_o), 32'd1);
            end
        end
    end

    task automatic do_op(input bit s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eq,
                         input logic [W-1:0] er, input bit ez,
                         input int hold);
        logic [W-1:0] mq, mr;
        logic         mz;
        int           lat;
        model(s, a, b, mq, mr, mz);
        chk("model_q", mq, eq);
        chk("model_r", mr, er);
        chk("model_z", 32'(mz), 32'(ez));
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready_o), 32'd1);
        exp_q      = mq;
        exp_r      = mr;
        exp_z      = mz;
        exp_live   = 1'b1;
        in_valid_i = 1'b1;
        signed_i   = s;
        dividend_i = a;
        divisor_i  = b;
        @(negedge clk);
        in_valid_i = 1'b0;
        dividend_i = $urandom;
        divisor_i  = $urandom;
        signed_i   = 1'($urandom);
        lat = 0;
        while (!out_valid_o && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 100) begin
            chk("timeout_valid", 32'(out_valid_o), 32'd1);
        end
        chk("latency", lat, ez ? 32'd0 : 32'(W));
        chk("lit_q", quotient_o, eq);
        chk("lit_r", remainder_o, er);
        chk("lit_z", 32'(div_by_zero_o), 32'(ez));
        for (int i = 0; i < hold; i++) begin
            in_valid_i = 1'($urandom);
            dividend_i = $urandom;
            divisor_i  = $urandom;
            @(negedge clk);
            chk("hold_in_ready", 32'(in_ready_o), 32'd0);
            chk("hold_valid", 32'(out_valid_o), 32'd1);
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
        exp_live    = 1'b0;
        chk("valid_drop", 32'(out_valid_o), 32'd0);
        chk("in_ready_back", 32'(in_ready_o), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_quotient"}, quotient_o, 32'd0);
        chk({tag, "_remainder"}, remainder_o, 32'd0);
        chk({tag, "_dbz"}, 32'(div_by_zero_o), 32'd0);
        chk({tag, "_valid"}, 32'(out_valid_o), 32'd0);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready_o), 32'd1);
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12;
        chk_reset_vals("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_vals("rst_rel");

        do_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 0);
        do_op(1'b1, -32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 0);
        do_op(1'b1, 32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 1'b0, 0);
        do_op(1'b1, -32'sd100, -32'sd7, 32'd14, 32'hFFFF_FFFE, 1'b0, 0);
        do_op(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 0);
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,
              1'b0, 0);
        do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000,
              1'b0, 0);
        do_op(1'b0, 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 0);
        do_op(1'b0, 32'd1000, 32'd33, 32'd30, 32'd10, 1'b0, 5);

        // Abort at CALC cycle 10; the result must never appear.
        @(negedge clk);
        exp_live   = 1'b0;
        in_valid_i = 1'b1;
        signed_i   = 1'b0;
        dividend_i = 32'd100;
        divisor_i  = 32'd7;
        @(negedge clk);
        in_valid_i = 1'b0;
        chk("abort_busy_calc", 32'(busy_o), 32'd1);
        repeat (9) @(negedge clk);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_in_ready", 32'(in_ready_o), 32'd1);
        chk("abort_dbz", 32'(div_by_zero_o), 32'd0);
        repeat (40) @(negedge clk);
        chk("abort_idle", 32'(in_ready_o), 32'd1);

        // clear_i beats a pending accept in IDLE.
        clear_i    = 1'b1;
        in_valid_i = 1'b1;
        @(negedge clk);
        clear_i    = 1'b0;
        in_valid_i = 1'b0;
        chk("clear_no_accept", 32'(busy_o), 32'd0);

        do_op(1'b0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 0);
        do_op(1'b1, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 2);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        in_valid_i = 1'b1;
        signed_i   = 1'b0;
        dividend_i = 32'd555;
        divisor_i  = 32'd11;
        @(negedge clk);
        in_valid_i = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        do_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
